// File: rtl/parameters.sv
// Shared configuration constants and state encoding for the
// configuration register loader.
package parameters;

    localparam int CONF_REGISTERS_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } conf_ld_state_t;

endpackage

// File: rtl/conf_reg_loader.sv
// Streams a block of memory words into the configuration register
// file and shares its single write port with direct host writes.
module conf_reg_loader #(
    parameter int CONF_REGISTERS_SIZE = parameters::CONF_REGISTERS_SIZE,
    parameter int MEM_ADDR_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] src_base,
    input  logic [31:0]           dst_base,
    input  logic [7:0]            count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_rd_en,
    output logic [MEM_ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]           mem_rd_data,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [31:0]           host_addr,
    input  logic [31:0]           host_data,
    output logic                  wr_en_ext,
    output logic [31:0]           wr_addr_ext,
    output logic [31:0]           wr_data_ext
);

    import parameters::*;

    localparam logic [32:0] SIZE33 = 33'(CONF_REGISTERS_SIZE);

    conf_ld_state_t state;

    logic [31:0] dst_q;
    logic [7:0]  cnt_q;
    logic [7:0]  k_q;

    logic        ld_wr_q;
    logic [31:0] ld_addr_q;
    logic        host_wr_q;
    logic [31:0] host_addr_q;
    logic [31:0] host_data_q;

    logic [32:0] ld_sum;
    logic        ld_oor;
    logic        host_oor;
    logic        host_acc;
    logic        last_rd;

    // Destination index of the read in flight; the carry bit
    // catches 32-bit wrap-around so it counts as out of range.
    always_comb begin
        ld_sum   = {1'b0, dst_q} + {25'b0, k_q};
        ld_oor   = ld_sum >= SIZE33;
        host_oor = {1'b0, host_addr} >= SIZE33;
        host_ready = (state == IDLE) && !start;
        host_acc = host_valid && host_ready;
        last_rd  = k_q == (cnt_q - 8'd1);
    end

    // Load sequencer with registered status and read strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        dst_q <= dst_base;
                        cnt_q <= count;
                        k_q   <= '0;
                        if (count != 8'd0) begin
                            state       <= LOAD;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= src_base;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (host_acc && host_oor) begin
                        err <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_oor) begin
                        err <= 1'b1;
                    end
                    if (last_rd) begin
                        state     <= DRAIN;
                        mem_rd_en <= 1'b0;
                    end else begin
                        k_q         <= k_q + 8'd1;
                        mem_rd_addr <= mem_rd_addr + MEM_ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write pipeline: one stage each for loader reads and host beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_wr_q     <= 1'b0;
            ld_addr_q   <= '0;
            host_wr_q   <= 1'b0;
            host_addr_q <= '0;
            host_data_q <= '0;
        end else begin
            ld_wr_q   <= mem_rd_en && !ld_oor;
            ld_addr_q <= ld_sum[31:0];
            host_wr_q <= host_acc && !host_oor;
            if (host_acc) begin
                host_addr_q <= host_addr;
                host_data_q <= host_data;
            end
        end
    end

    // Host beats and loader writes never overlap, so a simple
    // select on the host stage is enough for the shared port.
    always_comb begin
        wr_en_ext   = ld_wr_q || host_wr_q;
        wr_addr_ext = host_wr_q ? host_addr_q : ld_addr_q;
        wr_data_ext = host_wr_q ? host_data_q : mem_rd_data;
    end

endmodule

// File: tb/tb_conf_reg_loader.sv
// Scoreboard bench for conf_reg_loader: expected reads, writes and
// done pulses are queued at stimulus time and matched on output.
module tb_conf_reg_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] src_base;
    logic [31:0] dst_base;
    logic [7:0]  count;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] host_addr;
    logic [31:0] host_data;
    logic        wr_en_ext;
    logic [31:0] wr_addr_ext;
    logic [31:0] wr_data_ext;

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t rdq[$];
    ev_t wrq[$];
    int  dnq[$];
    ev_t e;
    int  dc;

    int cyc;
    int n_chk;
    int n_err;

    conf_reg_loader #(
        .CONF_REGISTERS_SIZE(16),
        .MEM_ADDR_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .src_base(src_base),
        .dst_base(dst_base),
        .count(count),
        .busy(busy),
        .done(done),
        .err(err),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .host_addr(host_addr),
        .host_data(host_data),
        .wr_en_ext(wr_en_ext),
        .wr_addr_ext(wr_addr_ext),
        .wr_data_ext(wr_data_ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memw(input logic [15:0] a);
        if (a == 16'h0040) return 32'hA;
        if (a == 16'h0041) return 32'hB;
        if (a == 16'h0042) return 32'hC;
        return {16'hC0DE, a};
    endfunction

    // One-cycle-latency memory model
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= memw(mem_rd_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor matching DUT events against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (mem_rd_en) begin
                if (rdq.size() == 0) check("rd_unexp", 1, 0);
                else begin
                    e = rdq.pop_front();
                    check("rd_cyc", cyc, e.c);
                    check("rd_addr", {16'b0, mem_rd_addr}, e.a);
                end
            end
            if (wr_en_ext) begin
                if (wrq.size() == 0) check("wr_unexp", wr_addr_ext, 32'hDEAD);
                else begin
                    e = wrq.pop_front();
                    check("wr_cyc", cyc, e.c);
                    check("wr_addr", wr_addr_ext, e.a);
                    check("wr_data", wr_data_ext, e.d);
                end
            end
            if (done) begin
                if (dnq.size() == 0) check("done_unexp", 1, 0);
                else begin
                    dc = dnq.pop_front();
                    check("done_cyc", cyc, dc);
                end
            end
        end
    end

    // Queue the reads, writes and done pulse a load started in
    // period p should produce; returns whether any index is out of range.
    function automatic logic push_load(input int p, input logic [15:0] src,
                                       input logic [31:0] dst,
                                       input int n);
        logic        oor;
        logic [15:0] sa;
        logic [32:0] idx;
        oor = 1'b0;
        for (int k = 0; k < n; k++) begin
            sa  = src + 16'(k);
            idx = {1'b0, dst} + 33'(k);
            rdq.push_back('{p + 1 + k, {16'b0, sa}, 32'b0});
            if (idx < 33'd16)
                wrq.push_back('{p + 2 + k, idx[31:0], memw(sa)});
            else
                oor = 1'b1;
        end
        dnq.push_back(n == 0 ? p + 1 : p + n + 2);
        return oor;
    endfunction

    task automatic do_load(input logic [15:0] src, input logic [31:0] dst,
                           input int n);
        int   p;
        int   nb;
        logic oor;
        @(posedge clk); #1;
        start    = 1'b1;
        src_base = src;
        dst_base = dst;
        count    = 8'(n);
        p   = cyc;
        oor = push_load(p, src, dst, n);
        @(posedge clk); #1;
        start = 1'b0;
        nb = 0;
        while (busy && nb < 300) begin
            nb++;
            @(posedge clk); #1;
        end
        check("busy_len", nb, n == 0 ? 1 : n + 2);
        check("load_err", {31'b0, err}, {31'b0, oor});
    endtask

    task automatic host_wr(input logic [31:0] a, input logic [31:0] d,
                           input logic exp_err);
        int p;
        @(posedge clk); #1;
        host_valid = 1'b1;
        host_addr  = a;
        host_data  = d;
        #1;
        check("host_ready", {31'b0, host_ready}, 1);
        p = cyc;
        if (a < 32'd16) wrq.push_back('{p + 1, a, d});
        @(posedge clk); #1;
        host_valid = 1'b0;
        @(posedge clk); #1;
        check("host_err", {31'b0, err}, {31'b0, exp_err});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   p;
        int   a;
        int   nb;
        logic oor;
        n_chk = 0;
        n_err = 0;
        mem_rd_data = '0;
        reset      = 1'b0;
        start      = 1'b0;
        src_base   = '0;
        dst_base   = '0;
        count      = '0;
        host_valid = 1'b0;
        host_addr  = '0;
        host_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_rden", {31'b0, mem_rd_en}, 0);
        check("rst_wren", {31'b0, wr_en_ext}, 0);
        check("rst_rdaddr", {16'b0, mem_rd_addr}, 0);
        check("rst_wraddr", wr_addr_ext, 0);
        reset = 1'b1;

        host_wr(32'd2, 32'h1, 1'b0);
        do_load(16'h0040, 32'd0, 3);
        host_wr(32'd16, 32'h77, 1'b1);
        do_load(16'h0100, 32'd14, 4);
        do_load(16'h0200, 32'd5, 2);
        do_load(16'hFFFF, 32'hFFFF_FFFF, 2);
        do_load(16'h0300, 32'd1, 0);
        do_load(16'h0010, 32'd0, 16);

        // start and host_valid together: start wins, host waits
        @(posedge clk); #1;
        start      = 1'b1;
        src_base   = 16'h0040;
        dst_base   = 32'd8;
        count      = 8'd3;
        host_valid = 1'b1;
        host_addr  = 32'd5;
        host_data  = 32'h55;
        #1;
        check("coll_ready", {31'b0, host_ready}, 0);
        p   = cyc;
        oor = push_load(p, 16'h0040, 32'd8, 3);
        @(posedge clk); #1;
        start = 1'b0;
        nb = 0;
        while (!host_ready && nb < 300) begin
            nb++;
            @(posedge clk); #1;
        end
        a = cyc;
        check("coll_acc_cyc", a, p + 3 + 3);
        wrq.push_back('{a + 1, 32'd5, 32'h55});
        @(posedge clk); #1;
        host_valid = 1'b0;
        check("coll_err", {31'b0, err}, {31'b0, oor});

        // reset during LOAD while the k=1 read is about to issue
        @(posedge clk); #1;
        start    = 1'b1;
        src_base = 16'h0080;
        dst_base = 32'd3;
        count    = 8'd4;
        p = cyc;
        rdq.push_back('{p + 1, 32'h80, 32'b0});
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_rden", {31'b0, mem_rd_en}, 0);
        check("mid_wren", {31'b0, wr_en_ext}, 0);
        check("mid_busy", {31'b0, busy}, 0);
        check("mid_done", {31'b0, done}, 0);
        check("mid_rdaddr", {16'b0, mem_rd_addr}, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        do_load(16'h0041, 32'd10, 2);

        repeat (5) @(posedge clk);
        #1;
        check("left_rd", rdq.size(), 0);
        check("left_wr", wrq.size(), 0);
        check("left_done", dnq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/conf_reg_loader.md
# conf_reg_loader

Sequencer that fills the accelerator configuration register file, e.g. MEMORY_POINTER_FC, FIRST_INDEX_FC_LOG and EXECUTION_FRAME_BY_FRAME, from a block of words in on-chip memory, and shares the register file's single write port with direct host writes. It sits between the SoC host/config memory and the configuration register file, and drives that file's `wr_en_ext/wr_addr_ext/wr_data_ext` port. A load of N words streams at one word per cycle.

## Interface
- CONF_REGISTERS_SIZE, default from `parameters` package (16): number of configuration registers; valid write addresses are 0..CONF_REGISTERS_SIZE-1.
- MEM_ADDR_W, default 16: source memory address width.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- start  in  1  load request pulse; sampled only in IDLE.
- src_base  in  MEM_ADDR_W  first memory word address; sampled with start.
- dst_base  in  32  first register index; sampled with start.
- count  in  8  number of words to load; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  sticky out-of-range flag; cleared by an accepted start.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  MEM_ADDR_W  memory read address.
- mem_rd_data  in  32  read data, valid exactly 1 cycle after mem_rd_en.
- host_valid  in  1  host single-beat write request.
- host_ready  out  1  host write accepted when valid and ready are both high.
- host_addr  in  32  host target register index.
- host_data  in  32  host write data.
- wr_en_ext  out  1  register-file write enable.
- wr_addr_ext  out  32  register-file write index.
- wr_data_ext  out  32  register-file write data.

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE + start with count>0 → LOAD. Latch src_base, dst_base and count; clear err.
- IDLE + start with count==0 → DONE. No reads or writes occur; err is still cleared.
- LOAD:
  - Assert mem_rd_en every cycle. mem_rd_addr = src_base + k, for k = 0..count-1.
  - After the read with k = count-1, go to DRAIN.
- DRAIN: one cycle, in which the last read data is written. Then go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- Write pipeline:
  - A 1-stage register holds the valid flag and destination index dst_base + k of each issued read.
  - The following cycle: wr_en_ext = that flag, wr_addr_ext = that index, wr_data_ext = mem_rd_data (combinational pass-through).
- Destination range check:
  - Any dst_base + k ≥ CONF_REGISTERS_SIZE: the read is still issued, wr_en_ext is suppressed for that word, and err is set.
  - Index arithmetic is 32-bit unsigned; wrap-around counts as out of range.
- Host path:
  - host_ready = (state==IDLE) && !start. start has priority over host_valid in the same cycle.
  - An accepted beat registers host_addr and host_data. The next cycle drives wr_en_ext=1 with those values.
  - An out-of-range host_addr suppresses the write and sets err.
- The output mux selects the loader or the host pipeline register. They never collide, because host beats are accepted only in IDLE and a load's first write occurs ≥2 cycles after start.
- start while busy is ignored.
- src_base + k wraps modulo 2^MEM_ADDR_W.

## Timing
- Reset values:
  - State IDLE.
  - busy, done, err, mem_rd_en, wr_en_ext, host_ready-internal regs = 0.
  - mem_rd_addr, wr_addr_ext = 0. wr_data_ext follows mem_rd_data, but wr_en_ext = 0.
- Reset asserted mid-load: immediate return to IDLE, all pending writes dropped, no done pulse.
- Load latency, with start sampled at edge T:
  - Reads in cycles T+1 .. T+N.
  - Writes in cycles T+2 .. T+N+1; the last write falls in DRAIN.
  - done in cycle T+N+2. IDLE from T+N+3.
- count==0: done in cycle T+1.
- Host write latency: 1 cycle from handshake to wr_en_ext. Throughput is 1 beat/cycle in IDLE.
- busy is high from T+1 through the done cycle inclusive.

## Structure
- In `parameters` package: CONF_REGISTERS_SIZE, and a state enum typedef `conf_ld_state_t` {IDLE, LOAD, DRAIN, DONE}.
- Single module, no sub-modules. The write pipeline register and output mux are inline.

## Test plan
- Host write in IDLE: host_valid=1, addr=2, data=0x1 → host_ready=1; next cycle wr_en_ext=1, wr_addr_ext=2, wr_data_ext=0x1; no other writes.
- Load, src_base=0x40, dst_base=0, count=3, mem[0x40..0x42]=0xA,0xB,0xC:
  - reads at 0x40..0x42 in T+1..T+3;
  - writes (0,0xA),(1,0xB),(2,0xC) in T+2..T+4;
  - done pulse at T+5; err=0.
- Out-of-range load, dst_base=14, count=4, size 16 → indices 14 and 15 written; 16 and 17 suppressed; err=1 after the load; done still pulses.
- Simultaneous start and host_valid in IDLE → host_ready=0, load proceeds. The host beat is accepted in the first IDLE cycle after done.
- count=0 start → no mem_rd_en, no wr_en_ext, done at T+1, busy high only in T+1.
- Reset pulled low during LOAD at k=1 → outputs 0 immediately, no further writes, no done. After release, a new load executes normally.
